// File: rtl/usb_ep_out.sv
// OUT/SETUP endpoint receive controller. It buffers one packet per endpoint
// and owns the data toggle and stall flag of each endpoint. It also picks the
// handshake (ACK/NAK/STALL/none) that ends every OUT and SETUP transaction.
module usb_ep_out #(
   parameter int N_EP    = 4,
   parameter int MAX_PKT = 64,
   parameter int EP_W    = (N_EP > 1) ? $clog2(N_EP) : 1,
   parameter int LEN_W   = $clog2(MAX_PKT + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tok_valid,
   input  logic [3:0]             tok_pid,
   input  logic [3:0]             tok_ep,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   input  logic                   rx_pid1,
   input  logic                   rx_end,
   input  logic                   rx_crc_ok,
   output logic                   hs_valid,
   output logic [1:0]             hs_code,
   input  logic [N_EP-1:0]        ep_en,
   input  logic [N_EP-1:0]        stall_set,
   input  logic [N_EP-1:0]        stall_clr,
   output logic [N_EP-1:0]        ep_full,
   output logic                   setup_flag,
   input  logic [EP_W-1:0]        rd_ep,
   input  logic                   rd_en,
   output logic [7:0]             rd_data,
   output logic [LEN_W-1:0]       rd_len,
   input  logic                   rd_done
);
   localparam int PTR_W = $clog2(MAX_PKT);
   localparam int DEPTH = N_EP << PTR_W;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RECV    = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;
   localparam logic [1:0] S_HS      = 2'd3;

   localparam logic [1:0] HS_ACK   = 2'b00;
   localparam logic [1:0] HS_NAK   = 2'b01;
   localparam logic [1:0] HS_STALL = 2'b10;

   localparam logic [3:0] PID_OUT   = 4'b0001;
   localparam logic [3:0] PID_SETUP = 4'b1101;

   localparam logic [4:0]       N_EP_L = 5'(N_EP);
   localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(MAX_PKT);

   logic [1:0]                  state;
   logic [EP_W-1:0]             cur_ep;
   logic                        cur_setup;
   logic                        ovf;
   logic [LEN_W-1:0]            wptr;
   logic [1:0]                  pend_code;
   logic [N_EP-1:0]             toggle;
   logic [N_EP-1:0]             stall;
   logic [N_EP-1:0][LEN_W-1:0]  len;
   logic [N_EP-1:0][LEN_W-1:0]  rptr;
   logic [7:0]                  mem [DEPTH];

   logic [EP_W-1:0]             tok_idx;
   logic                        tok_in_range;
   logic                        tok_out;
   logic                        tok_setup;
   logic                        wr_en;
   logic [LEN_W-1:0]            rd_ptr;
   logic [PTR_W-1:0]            rd_addr_ptr;
   logic                        rd_hit;

   assign tok_idx      = tok_ep[EP_W-1:0];
   assign tok_in_range = ({1'b0, tok_ep} < N_EP_L);
   assign tok_out      = tok_valid && (tok_pid == PID_OUT) && tok_in_range && ep_en[tok_idx];
   assign tok_setup    = tok_valid && (tok_pid == PID_SETUP) && (tok_ep == 4'd0) && ep_en[0];

   // Duplicate OUT packets (wrong toggle) are never written, so the stale
   // committed payload survives a host retry untouched.
   assign wr_en = (state == S_RECV) && rx_valid && !rx_end && !tok_valid && (wptr != MAX_L) &&
                  (cur_setup || (rx_pid1 == toggle[cur_ep]));

   // Once the pointer hits the committed length, reads keep returning the last byte.
   assign rd_len      = len[rd_ep];
   assign rd_ptr      = rptr[rd_ep];
   assign rd_hit      = rd_en && ep_full[rd_ep] && (rd_len != '0);
   assign rd_addr_ptr = (rd_ptr < rd_len) ? PTR_W'(rd_ptr) : PTR_W'(rd_len - LEN_W'(1));

   // Packet RAM write port, addressed {endpoint, byte pointer}
   always_ff @(posedge clk) begin
      if (wr_en) mem[{cur_ep, wptr[PTR_W-1:0]}] <= rx_data;
   end

   // Receive FSM, per-endpoint state and application read port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cur_ep     <= '0;
         cur_setup  <= 1'b0;
         ovf        <= 1'b0;
         wptr       <= '0;
         pend_code  <= HS_ACK;
         hs_valid   <= 1'b0;
         hs_code    <= HS_ACK;
         toggle     <= '0;
         stall      <= '0;
         ep_full    <= '0;
         setup_flag <= 1'b0;
         len        <= '0;
         rptr       <= '0;
         rd_data    <= '0;
      end else begin
         hs_valid <= 1'b0;

         for (int i = 0; i < N_EP; i++) begin
            if (stall_clr[i]) begin
               stall[i]  <= 1'b0;
               toggle[i] <= 1'b0;
            end else if (stall_set[i]) begin
               stall[i] <= 1'b1;
            end
         end

         if (rd_hit) begin
            rd_data <= mem[{rd_ep, rd_addr_ptr}];
            if (rd_ptr < rd_len) rptr[rd_ep] <= rd_ptr + LEN_W'(1);
         end
         if (rd_done) begin
            ep_full[rd_ep] <= 1'b0;
            rptr[rd_ep]    <= '0;
            if (rd_ep == '0) setup_flag <= 1'b0;
         end

         // A token in any state starts a new transaction, so a lost rx_end
         // simply aborts the packet in flight without committing it.
         if (tok_out) begin
            cur_ep    <= tok_idx;
            cur_setup <= 1'b0;
            wptr      <= '0;
            ovf       <= 1'b0;
            if (stall[tok_idx]) begin
               state     <= S_DISCARD;
               pend_code <= HS_STALL;
            end else if (ep_full[tok_idx]) begin
               state     <= S_DISCARD;
               pend_code <= HS_NAK;
            end else begin
               state <= S_RECV;
            end
         end else if (tok_setup) begin
            // SETUP takes EP0 over unconditionally, ahead of any rd_done this cycle
            cur_ep     <= '0;
            cur_setup  <= 1'b1;
            wptr       <= '0;
            ovf        <= 1'b0;
            state      <= S_RECV;
            stall[0]   <= 1'b0;
            ep_full[0] <= 1'b0;
            rptr[0]    <= '0;
            setup_flag <= 1'b0;
         end else if (tok_valid) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_RECV: begin
                  if (rx_end) begin
                     if (!rx_crc_ok || ovf) begin
                        state <= S_IDLE;
                     end else begin
                        state    <= S_HS;
                        hs_valid <= 1'b1;
                        hs_code  <= HS_ACK;
                        if (cur_setup) begin
                           ep_full[0] <= 1'b1;
                           len[0]     <= wptr;
                           setup_flag <= 1'b1;
                           toggle[0]  <= 1'b1;
                        end else if (rx_pid1 == toggle[cur_ep]) begin
                           ep_full[cur_ep] <= 1'b1;
                           len[cur_ep]     <= wptr;
                           toggle[cur_ep]  <= ~toggle[cur_ep];
                        end
                     end
                  end else if (rx_valid) begin
                     if (wptr == MAX_L) ovf  <= 1'b1;
                     else               wptr <= wptr + LEN_W'(1);
                  end
               end
               S_DISCARD: begin
                  if (rx_end) begin
                     state    <= S_HS;
                     hs_valid <= 1'b1;
                     hs_code  <= pend_code;
                  end
               end
               S_HS:    state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_usb_ep_out.sv
// Bench for usb_ep_out. It runs a table of transactions with hand-derived
// results and hand-written corner sequences. It then runs random traffic
// checked against a transaction-level endpoint model.
module tb_usb_ep_out;
   localparam logic [3:0] OUT   = 4'b0001;
   localparam logic [3:0] SETUP = 4'b1101;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tok_valid, rx_valid, rx_pid1, rx_end, rx_crc_ok;
   logic [3:0] tok_pid, tok_ep;
   logic [7:0] rx_data;
   logic       hs_valid;
   logic [1:0] hs_code;
   logic [3:0] ep_en, stall_set, stall_clr, ep_full;
   logic       setup_flag;
   logic [1:0] rd_ep;
   logic       rd_en, rd_done;
   logic [7:0] rd_data;
   logic [6:0] rd_len;

   usb_ep_out #(.N_EP(4), .MAX_PKT(64)) dut (
      .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_pid(tok_pid), .tok_ep(tok_ep),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_pid1(rx_pid1), .rx_end(rx_end),
      .rx_crc_ok(rx_crc_ok), .hs_valid(hs_valid), .hs_code(hs_code), .ep_en(ep_en),
      .stall_set(stall_set), .stall_clr(stall_clr), .ep_full(ep_full), .setup_flag(setup_flag),
      .rd_ep(rd_ep), .rd_en(rd_en), .rd_data(rd_data), .rd_len(rd_len), .rd_done(rd_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] pkt [80];

   // transaction-level model state
   logic       m_full [4];
   logic       m_tog [4];
   logic       m_stall [4];
   int         m_len [4];
   int         m_rptr [4];
   logic [7:0] m_buf [4][64];
   logic       m_setup;
   logic [7:0] m_rd;

   typedef struct {
      logic [3:0] pid;
      logic [3:0] ep;
      logic       p1;
      int         n;
      logic [7:0] base;
      logic       crc;
      logic       ehv;
      logic [1:0] ehc;
      logic [3:0] efull;
   } vec_t;
   vec_t vt [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) pkt[i] = base + 8'(i);
   endtask

   task automatic run(input logic [3:0] pid, input logic [3:0] ep, input logic p1, input int n,
                      input logic crc, output logic hv, output logic [1:0] hc, output logic hv2);
      tok_valid = 1'b1; tok_pid = pid; tok_ep = ep;
      cyc();
      tok_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         rx_valid = 1'b1; rx_data = pkt[i]; rx_pid1 = p1;
         cyc();
      end
      rx_valid = 1'b0; rx_pid1 = p1;
      rx_end = 1'b1; rx_crc_ok = crc;
      cyc();
      rx_end = 1'b0; rx_crc_ok = 1'b0;
      hv = hs_valid; hc = hs_code;
      cyc();
      hv2 = hs_valid;
   endtask

   task automatic xchk(input string nm, input logic [3:0] pid, input logic [3:0] ep, input logic p1,
                       input int n, input logic crc, input logic ehv, input logic [1:0] ehc);
      logic hv, hv2;
      logic [1:0] hc;
      run(pid, ep, p1, n, crc, hv, hc, hv2);
      chk({nm, " hs_valid"}, 32'(hv), 32'(ehv));
      if (ehv) chk({nm, " hs_code"}, 32'(hc), 32'(ehc));
      chk({nm, " hs_one_cycle"}, 32'(hv2), 32'd0);
   endtask

   task automatic rd(input logic [1:0] e);
      rd_ep = e; rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
   endtask

   task automatic done(input logic [1:0] e);
      rd_ep = e; rd_done = 1'b1;
      cyc();
      rd_done = 1'b0;
   endtask

   task automatic clear_inputs();
      tok_valid = 0; tok_pid = 0; tok_ep = 0; rx_valid = 0; rx_data = 0; rx_pid1 = 0;
      rx_end = 0; rx_crc_ok = 0; stall_set = 0; stall_clr = 0; rd_ep = 0; rd_en = 0; rd_done = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      for (int e = 0; e < 4; e++) begin
         m_full[e] = 0; m_tog[e] = 0; m_stall[e] = 0; m_len[e] = 0; m_rptr[e] = 0;
      end
      m_setup = 0; m_rd = 8'h00;
   endtask

   // Endpoint behaviour expressed as whole-transaction rules
   task automatic model_xact(input logic [3:0] pid, input logic [3:0] ep, input logic p1, input int n,
                             input logic crc, output logic ehv, output logic [1:0] ehc);
      int e;
      e = int'(ep);
      ehv = 0; ehc = 2'b00;
      if (pid == OUT && e < 4 && ep_en[e]) begin
         if (m_stall[e]) begin ehv = 1; ehc = 2'b10; end
         else if (m_full[e]) begin ehv = 1; ehc = 2'b01; end
         else if (crc && n <= 64) begin
            ehv = 1;
            if (p1 == m_tog[e]) begin
               m_full[e] = 1; m_len[e] = n; m_rptr[e] = 0; m_tog[e] = !m_tog[e];
               for (int i = 0; i < n; i++) m_buf[e][i] = pkt[i];
            end
         end
      end else if (pid == SETUP && e == 0 && ep_en[0]) begin
         m_stall[0] = 0; m_full[0] = 0; m_setup = 0; m_rptr[0] = 0;
         if (crc && n <= 64) begin
            ehv = 1;
            m_full[0] = 1; m_len[0] = n; m_setup = 1; m_tog[0] = 1;
            for (int i = 0; i < n; i++) m_buf[0][i] = pkt[i];
         end
      end
   endtask

   task automatic model_rd(input int e);
      if (m_full[e]) begin
         if (m_rptr[e] < m_len[e]) begin
            m_rd = m_buf[e][m_rptr[e]];
            m_rptr[e]++;
         end else if (m_len[e] > 0) begin
            m_rd = m_buf[e][m_len[e]-1];
         end
      end
   endtask

   logic       hv, hv2, ehv, p1, crc;
   logic [1:0] hc, ehc;
   logic [3:0] pid, ep, ss, sc;
   int         n, r, e, k;

   initial begin
      // Overflow (65 bytes) and bad CRC leave ep3's toggle at DATA0, so DATA1 is a duplicate
      vt[0]  = '{OUT,     4'd1, 1'b0,  8, 8'h10, 1'b1, 1'b1, 2'b00, 4'b0010};
      vt[1]  = '{OUT,     4'd1, 1'b1,  4, 8'h20, 1'b1, 1'b1, 2'b01, 4'b0010};
      vt[2]  = '{OUT,     4'd2, 1'b0,  3, 8'h30, 1'b1, 1'b1, 2'b00, 4'b0110};
      vt[3]  = '{OUT,     4'd2, 1'b1,  2, 8'h38, 1'b1, 1'b1, 2'b01, 4'b0110};
      vt[4]  = '{OUT,     4'd3, 1'b0, 65, 8'h00, 1'b1, 1'b0, 2'b00, 4'b0110};
      vt[5]  = '{OUT,     4'd3, 1'b0,  5, 8'h40, 1'b0, 1'b0, 2'b00, 4'b0110};
      vt[6]  = '{OUT,     4'd3, 1'b1,  5, 8'h48, 1'b1, 1'b1, 2'b00, 4'b0110};
      vt[7]  = '{OUT,     4'd3, 1'b0,  0, 8'h00, 1'b1, 1'b1, 2'b00, 4'b1110};
      vt[8]  = '{4'b1001, 4'd0, 1'b0,  2, 8'h50, 1'b1, 1'b0, 2'b00, 4'b1110};
      vt[9]  = '{OUT,     4'd5, 1'b0,  2, 8'h58, 1'b1, 1'b0, 2'b00, 4'b1110};
      vt[10] = '{OUT,     4'd0, 1'b0,  4, 8'h60, 1'b1, 1'b1, 2'b00, 4'b1111};

      clear_inputs();
      ep_en = 4'hF;
      rst_n = 1'b0;
      #1;
      chk("reset ep_full", 32'(ep_full), 32'd0);
      chk("reset hs_valid", 32'(hs_valid), 32'd0);
      chk("reset hs_code", 32'(hs_code), 32'd0);
      chk("reset setup_flag", 32'(setup_flag), 32'd0);
      chk("reset rd_data", 32'(rd_data), 32'd0);
      do_reset();

      for (int i = 0; i < 11; i++) begin
         fill(vt[i].base, vt[i].n);
         xchk($sformatf("vec%0d", i), vt[i].pid, vt[i].ep, vt[i].p1, vt[i].n, vt[i].crc,
              vt[i].ehv, vt[i].ehc);
         chk($sformatf("vec%0d ep_full", i), 32'(ep_full), 32'(vt[i].efull));
      end

      // read ep1 back, saturate, release; zero-length ep3 needs rd_done too
      rd_ep = 2'd1; #1;
      chk("ep1 rd_len", 32'(rd_len), 32'd8);
      for (int i = 0; i < 8; i++) begin
         rd(2'd1);
         chk($sformatf("ep1 byte%0d", i), 32'(rd_data), 32'(8'h10 + 8'(i)));
      end
      rd(2'd1);
      chk("ep1 saturated read", 32'(rd_data), 32'h17);
      done(2'd1);
      chk("ep1 released", 32'(ep_full), 32'b1101);
      rd(2'd1);
      chk("read empty keeps rd_data", 32'(rd_data), 32'h17);
      rd_ep = 2'd3; #1;
      chk("ep3 zero length", 32'(rd_len), 32'd0);
      rd(2'd3);
      chk("zero length read keeps rd_data", 32'(rd_data), 32'h17);
      done(2'd3);
      chk("ep3 released", 32'(ep_full), 32'b0101);

      // duplicate DATA0 on ep1 is ACKed but changes nothing; DATA1 then commits
      fill(8'h40, 3);
      xchk("ep1 dup", OUT, 4'd1, 1'b0, 3, 1'b1, 1'b1, 2'b00);
      rd_ep = 2'd1; #1;
      chk("ep1 dup not full", 32'(ep_full[1]), 32'd0);
      chk("ep1 dup len kept", 32'(rd_len), 32'd8);
      fill(8'h50, 2);
      xchk("ep1 data1", OUT, 4'd1, 1'b1, 2, 1'b1, 1'b1, 2'b00);
      rd_ep = 2'd1; #1;
      chk("ep1 data1 len", 32'(rd_len), 32'd2);
      rd(2'd1);
      chk("ep1 data1 byte0", 32'(rd_data), 32'h50);
      done(2'd1);

      // ep2 (still full): stall, disable, then set+clr together (clear wins, toggle to DATA0)
      stall_set = 4'b0100; cyc(); stall_set = 4'b0000;
      xchk("ep2 stall", OUT, 4'd2, 1'b1, 2, 1'b1, 1'b1, 2'b10);
      ep_en = 4'b1011;
      xchk("ep2 disabled", OUT, 4'd2, 1'b1, 2, 1'b1, 1'b0, 2'b00);
      ep_en = 4'hF;
      stall_set = 4'b0100; stall_clr = 4'b0100; cyc(); stall_set = 0; stall_clr = 0;
      xchk("ep2 clr wins", OUT, 4'd2, 1'b1, 2, 1'b1, 1'b1, 2'b01);
      done(2'd2);
      fill(8'h70, 2);
      xchk("ep2 toggle reset", OUT, 4'd2, 1'b0, 2, 1'b1, 1'b1, 2'b00);
      chk("ep2 committed", 32'(ep_full[2]), 32'd1);
      done(2'd2);

      // SETUP overrides a full and stalled EP0
      stall_set = 4'b0001; cyc(); stall_set = 0;
      xchk("ep0 stalled", OUT, 4'd0, 1'b1, 2, 1'b1, 1'b1, 2'b10);
      fill(8'h80, 8);
      xchk("setup", SETUP, 4'd0, 1'b0, 8, 1'b1, 1'b1, 2'b00);
      chk("setup_flag set", 32'(setup_flag), 32'd1);
      chk("setup ep_full", 32'(ep_full[0]), 32'd1);
      rd_ep = 2'd0; #1;
      chk("setup len", 32'(rd_len), 32'd8);
      rd(2'd0);
      chk("setup byte0", 32'(rd_data), 32'h80);
      done(2'd0);
      chk("setup_flag cleared", 32'(setup_flag), 32'd0);
      fill(8'h90, 3);
      xchk("ep0 data1 after setup", OUT, 4'd0, 1'b1, 3, 1'b1, 1'b1, 2'b00);
      rd_ep = 2'd0; #1;
      chk("ep0 data1 full", 32'(ep_full[0]), 32'd1);
      chk("ep0 data1 len", 32'(rd_len), 32'd3);
      done(2'd0);

      // lost rx_end: second token aborts the first packet on ep1
      fill(8'hA0, 3);
      tok_valid = 1; tok_pid = OUT; tok_ep = 4'd1; cyc(); tok_valid = 0;
      for (int i = 0; i < 3; i++) begin rx_valid = 1; rx_data = pkt[i]; rx_pid1 = 0; cyc(); end
      rx_valid = 0;
      fill(8'hB0, 2);
      xchk("abort then retry", OUT, 4'd1, 1'b0, 2, 1'b1, 1'b1, 2'b00);
      rd_ep = 2'd1; #1;
      chk("retry len", 32'(rd_len), 32'd2);
      rd(2'd1);
      chk("retry byte0", 32'(rd_data), 32'hB0);
      done(2'd1);

      // reset in the middle of a packet
      fill(8'hC8, 1);
      xchk("ep3 data1", OUT, 4'd3, 1'b1, 1, 1'b1, 1'b1, 2'b00);
      xchk("ep3 nak", OUT, 4'd3, 1'b0, 1, 1'b1, 1'b1, 2'b01);
      tok_valid = 1; tok_pid = OUT; tok_ep = 4'd1; cyc(); tok_valid = 0;
      for (int i = 0; i < 2; i++) begin rx_valid = 1; rx_data = 8'hEE; rx_pid1 = 1; cyc(); end
      #2 rst_n = 1'b0;
      #1;
      chk("mid reset ep_full", 32'(ep_full), 32'd0);
      chk("mid reset hs_code", 32'(hs_code), 32'd0);
      chk("mid reset hs_valid", 32'(hs_valid), 32'd0);
      chk("mid reset rd_data", 32'(rd_data), 32'd0);
      chk("mid reset setup_flag", 32'(setup_flag), 32'd0);
      do_reset();
      fill(8'hC0, 4);
      xchk("post reset", OUT, 4'd1, 1'b0, 4, 1'b1, 1'b1, 2'b00);
      rd_ep = 2'd1; #1;
      chk("post reset ep_full", 32'(ep_full), 32'b0010);
      chk("post reset len", 32'(rd_len), 32'd4);
      rd(2'd1);
      chk("post reset byte0", 32'(rd_data), 32'hC0);

      // random traffic against the model
      do_reset();
      for (int it = 0; it < 200; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            ss = 4'($urandom) & 4'($urandom);
            sc = 4'($urandom) & 4'($urandom) & 4'($urandom);
            stall_set = ss; stall_clr = sc; cyc(); stall_set = 0; stall_clr = 0;
            for (int j = 0; j < 4; j++) begin
               if (sc[j]) begin m_stall[j] = 0; m_tog[j] = 0; end
               else if (ss[j]) m_stall[j] = 1;
            end
         end
         ep_en = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
         r = $urandom_range(0, 9);
         pid = (r < 6) ? OUT : (r < 8) ? SETUP : (r == 8) ? 4'b1001 : 4'b0101;
         ep = (pid == SETUP && $urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 5));
         p1 = 1'($urandom);
         n = ($urandom_range(0, 9) == 0) ? $urandom_range(62, 66) : $urandom_range(0, 12);
         crc = ($urandom_range(0, 9) != 0);
         for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
         model_xact(pid, ep, p1, n, crc, ehv, ehc);
         run(pid, ep, p1, n, crc, hv, hc, hv2);
         chk($sformatf("rnd%0d hs_valid", it), 32'(hv), 32'(ehv));
         if (ehv) chk($sformatf("rnd%0d hs_code", it), 32'(hc), 32'(ehc));
         chk($sformatf("rnd%0d hs_one_cycle", it), 32'(hv2), 32'd0);
         chk($sformatf("rnd%0d ep_full", it), 32'(ep_full),
             32'({m_full[3], m_full[2], m_full[1], m_full[0]}));
         chk($sformatf("rnd%0d setup_flag", it), 32'(setup_flag), 32'(m_setup));
         if ($urandom_range(0, 1) == 1) begin
            e = $urandom_range(0, 3);
            rd_ep = 2'(e); #1;
            chk($sformatf("rnd%0d rd_len", it), 32'(rd_len), 32'(m_len[e]));
            k = $urandom_range(0, 4);
            for (int j = 0; j < k; j++) begin
               rd(2'(e));
               model_rd(e);
               chk($sformatf("rnd%0d rd_data", it), 32'(rd_data), 32'(m_rd));
            end
            if ($urandom_range(0, 1) == 1) begin
               done(2'(e));
               m_full[e] = 0; m_rptr[e] = 0;
               if (e == 0) m_setup = 0;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
      $fatal(1);
   end
endmodule

// File: doc/usb_ep_out.md
Name: usb_ep_out

Overview:
- Parametrised OUT/SETUP endpoint receive controller for the USB 2.0 FS device core.
- Sits between the SIE receive path (sie_bus) and the application.
- Owns one packet buffer, one data toggle and one stall flag per endpoint.
- Decides the handshake (ACK/NAK/STALL/none) for every OUT and SETUP transaction.

Parameters:
N_EP, 4, number of OUT endpoints, 1..16; endpoint 0 is the control endpoint
MAX_PKT, 64, max payload bytes per endpoint buffer, 8..64
EP_W, $clog2(N_EP) (min 1), derived endpoint index width
LEN_W, $clog2(MAX_PKT+1), derived length width

Ports:
clk  in  1  core clock, 48 MHz domain of the device core
rst_n  in  1  asynchronous, active-low reset
tok_valid  in  1  one-cycle strobe: token received with valid CRC5 and address match
tok_pid  in  4  token PID (OUT=4'b0001, SETUP=4'b1101, others ignored)
tok_ep  in  4  token endpoint number
rx_valid  in  1  data payload byte strobe (CRC16 bytes excluded)
rx_data  in  8  payload byte
rx_pid1  in  1  data PID of current packet, 0=DATA0 1=DATA1, valid from first rx_valid to rx_end
rx_end  in  1  one-cycle end-of-packet strobe
rx_crc_ok  in  1  CRC16 result, sampled with rx_end
hs_valid  out  1  one-cycle handshake request to SIE transmitter
hs_code  out  2  00 ACK, 01 NAK, 10 STALL
ep_en  in  N_EP  endpoint enable mask
stall_set  in  N_EP  per-endpoint stall set pulses
stall_clr  in  N_EP  per-endpoint stall clear pulses; also resets that endpoint toggle to DATA0
ep_full  out  N_EP  packet committed and waiting for application
setup_flag  out  1  EP0 buffer holds a SETUP packet
rd_ep  in  EP_W  application read endpoint select
rd_en  in  1  pop one byte from rd_ep buffer
rd_data  out  8  byte at read pointer, registered, valid 1 cycle after rd_en
rd_len  out  LEN_W  committed length of rd_ep buffer, combinational on rd_ep
rd_done  in  1  release rd_ep buffer

Behaviour:
- Reset (async, rst_n=0): FSM IDLE, all ep_full=0, toggles expect DATA0, stalls clear, setup_flag=0, hs_valid=0, hs_code=00, rd_data=0, read pointers 0.
- Storage: single N_EP*MAX_PKT byte RAM addressed {ep, ptr}.
- FSM states: IDLE, RECV, DISCARD, HS.
- IDLE, tok_valid, OUT, ep<N_EP, ep_en[ep]=1:
  - stall[ep] -> DISCARD, handshake STALL.
  - ep_full[ep] -> DISCARD, handshake NAK.
  - otherwise -> RECV, write ptr=0.
- IDLE, SETUP on ep0, ep_en[0]=1 -> RECV unconditionally (SETUP is never NAKed or STALLed).
  - On entry: clear stall[0] and ep_full[0].
  - The read pointer for ep0 is reset.
- IDLE, any other token, or ep disabled or out of range: stay IDLE, no handshake (host times out).
- RECV, each rx_valid: write byte, ptr+1; byte MAX_PKT+1 sets an overflow flag, and no RAM write occurs past MAX_PKT.
- RECV, rx_end:
  - crc bad or overflow -> IDLE, no handshake, buffer stays empty.
  - OUT, rx_pid1 == toggle: commit — ep_full=1, length=ptr, toggle flips, ACK.
  - OUT, rx_pid1 != toggle: duplicate — discard, toggle unchanged, ACK.
  - SETUP: always commit — setup_flag=1, toggle[0] set so next expected is DATA1, ACK.
- DISCARD: ignore bytes; on rx_end go to HS with the precomputed code (STALL/NAK), regardless of CRC.
- HS: hs_valid=1 for exactly one cycle, the cycle after rx_end; then IDLE.
- Handshake latency is fixed: rx_end at cycle n -> hs_valid at n+1.
- tok_valid arriving in RECV/DISCARD (lost rx_end): abort the current packet without commit and process the new token as in IDLE.
- Read side, rd_en while ep_full[rd_ep]:
  - rd_data = RAM[rd_ep, rptr]; rptr+1.
  - rptr saturates at rd_len; further reads return last byte.
- Read side, rd_en on an empty buffer: rd_data unchanged.
- rd_done: ep_full[rd_ep]=0, rptr=0; clears setup_flag if rd_ep=0.
- rd_done in the same cycle as a SETUP entry on ep0: SETUP wins.
- Zero-length OUT: committed with rd_len=0; requires rd_done.
- stall_set and stall_clr in the same cycle: clr wins.
- stall changes affect only transactions not yet in RECV/DISCARD.

Test Plan:
- OUT ep1, DATA0, 8 bytes 0x10..0x17, crc ok -> ACK at rx_end+1, ep_full[1]=1, rd_len=8; read yields 0x10..0x17; rd_done clears ep_full.
- Repeat OUT ep1 with DATA0 after a committed DATA0 -> ACK, buffer contents and length unchanged, toggle still expects DATA1.
- OUT ep2 while ep_full[2]=1 -> NAK; with stall[2] set -> STALL; with ep_en[2]=0 -> no hs_valid.
- SETUP ep0, 8 bytes, while ep_full[0]=1 and stall[0]=1 -> ACK, setup_flag=1, stall cleared, next OUT DATA1 ACKed and committed.
- OUT ep1, MAX_PKT+1 bytes, or crc bad -> no handshake, ep_full[1]=0, toggle unchanged.
- Assert rst_n low mid-RECV -> all outputs reset values immediately; next DATA0 OUT to ep1 commits.
